// File: rtl/pri_islip_sched_pkg.sv
// Shared types and helpers for the priority iSLIP scheduler.
package pri_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCEPT = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int pw_of(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  function automatic int ptr_inc(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pri_islip_sched_if.sv
// Request/decision bundle between the crossbar control path and the scheduler.
interface pri_islip_sched_if #(
  parameter int N = 4,
  parameter int P = 16
);
  import pri_sched_pkg::*;
  localparam int PW = pw_of(P);

  logic                          start;
  logic [N-1:0][N-1:0][PW-1:0]   pri_req_in;
  logic [N-1:0][N-1:0]           decision;
  logic                          decision_ready;
  logic                          busy;

  modport master (output start, pri_req_in, input decision, decision_ready, busy);
  modport slave  (input start, pri_req_in, output decision, decision_ready, busy);
endinterface

// File: rtl/pri_islip_sched_rr_arbiter.sv
// Combinational arbiter: highest priority wins, ties broken round-robin from ptr.
module pri_rr_arbiter
  import pri_sched_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int P  = 16,
  localparam int PW = pw_of(P),
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0][PW-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [N-1:0]         gnt,
  output logic [PW-1:0]        pri,
  output logic                 any_gnt
);

  logic [PW-1:0] max_s;
  logic [N-1:0]  gnt_s;
  logic          found_s;

  // Find the top priority, then scan ptr..N-1 followed by 0..ptr-1.
  always_comb begin
    max_s   = '0;
    gnt_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (req[k] > max_s) begin
        max_s = req[k];
      end else begin
        max_s = max_s;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found_s && (k >= int'(ptr)) && (max_s != '0) && (req[k] == max_s)) begin
        gnt_s[k] = 1'b1;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found_s && (k < int'(ptr)) && (max_s != '0) && (req[k] == max_s)) begin
        gnt_s[k] = 1'b1;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign gnt     = gnt_s;
  assign pri     = max_s;
  assign any_gnt = found_s;

endmodule

// File: rtl/pri_islip_sched.sv
// N x N priority iSLIP scheduler. Optional early exit when an iteration adds
// no pair: define PRI_ISLIP_EARLY_EXIT_EN.
module pri_islip_sched
  import pri_sched_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int P    = 16,
  parameter  int ITER = 4,
  localparam int PW   = pw_of(P),
  localparam int IW   = $clog2(N),
  localparam int CW   = $clog2(ITER + 1)
) (
  input  logic               clk,
  input  logic               reset,
  pri_islip_sched_if.slave   bus
);

  state_t                       state_r, state_nxt_s;
  logic [CW-1:0]                iter_r;
  logic [N-1:0][N-1:0][PW-1:0]  req_r;
  logic [N-1:0][N-1:0]          match_r;
  logic [N-1:0][N-1:0]          gnt_r;       // [output][input]
  logic [N-1:0][PW-1:0]         gnt_pri_r;
  logic [N-1:0][IW-1:0]         gnt_ptr_r;
  logic [N-1:0][IW-1:0]         acc_ptr_r;
  logic [N-1:0][N-1:0]          decision_r;
  logic                         decision_ready_r;
  logic                         busy_r;

  logic [N-1:0]                 in_matched_s, out_matched_s;
  logic [N-1:0][N-1:0][PW-1:0]  g_req_s, a_req_s;
  logic [N-1:0][N-1:0]          g_gnt_s, a_gnt_s;
  logic [N-1:0][PW-1:0]         g_pri_s, a_pri_s;
  logic [N-1:0]                 g_any_s, a_any_s;
  logic [N-1:0][N-1:0]          new_pair_s;  // [input][output]
  logic                         last_iter_s;

  // Matched-port flags and masked requests for both arbiter banks.
  always_comb begin
    in_matched_s  = '0;
    out_matched_s = '0;
    g_req_s       = '0;
    a_req_s       = '0;
    new_pair_s    = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (match_r[i][j]) begin
          in_matched_s[i]  = 1'b1;
          out_matched_s[j] = 1'b1;
        end else begin
          in_matched_s[i]  = in_matched_s[i];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        g_req_s[j][i] = (in_matched_s[i] || out_matched_s[j]) ? '0 : req_r[i][j];
        a_req_s[i][j] = (gnt_r[j][i] && !in_matched_s[i]) ? gnt_pri_r[j] : '0;
      end
      new_pair_s[i] = (a_any_s[i] && (a_pri_s[i] != '0)) ? a_gnt_s[i] : '0;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_arb
    pri_rr_arbiter #(.N(N), .P(P)) u_grant (
      .req     (g_req_s[g]),
      .ptr     (gnt_ptr_r[g]),
      .gnt     (g_gnt_s[g]),
      .pri     (g_pri_s[g]),
      .any_gnt (g_any_s[g])
    );
    pri_rr_arbiter #(.N(N), .P(P)) u_accept (
      .req     (a_req_s[g]),
      .ptr     (acc_ptr_r[g]),
      .gnt     (a_gnt_s[g]),
      .pri     (a_pri_s[g]),
      .any_gnt (a_any_s[g])
    );
  end

`ifdef PRI_ISLIP_EARLY_EXIT_EN
  assign last_iter_s = (iter_r == CW'(ITER - 1)) || (new_pair_s == '0);
`else
  assign last_iter_s = (iter_r == CW'(ITER - 1));
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT:  state_nxt_s = ACCEPT;
      ACCEPT: begin
        if (last_iter_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: request latch, grant registers, working match, pointers, outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_r           <= '0;
      req_r            <= '0;
      match_r          <= '0;
      gnt_r            <= '0;
      gnt_pri_r        <= '0;
      gnt_ptr_r        <= '0;
      acc_ptr_r        <= '0;
      decision_r       <= '0;
      decision_ready_r <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      decision_ready_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          busy_r <= bus.start;
          if (bus.start) begin
            req_r   <= bus.pri_req_in;
            match_r <= '0;
            iter_r  <= '0;
          end
        end
        GRANT: begin
          for (int j = 0; j < N; j++) begin
            gnt_r[j]     <= g_gnt_s[j];
            gnt_pri_r[j] <= g_any_s[j] ? g_pri_s[j] : '0;
          end
        end
        ACCEPT: begin
          match_r <= match_r | new_pair_s;
          iter_r  <= iter_r + CW'(1);
          // Pointers only advance on first-iteration accepts, which keeps iSLIP starvation-free.
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              if ((iter_r == '0) && new_pair_s[i][j]) begin
                gnt_ptr_r[j] <= IW'(ptr_inc(i, N));
                acc_ptr_r[i] <= IW'(ptr_inc(j, N));
              end
            end
          end
        end
        DONE: begin
          decision_r <= match_r;
          busy_r     <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.decision       = decision_r;
  assign bus.decision_ready = decision_ready_r;
  assign bus.busy           = busy_r;

endmodule

// File: tb/tb_pri_islip_sched.sv
// Directed self-checking bench for pri_islip_sched (N=4, P=16, ITER=4).
module tb_pri_islip_sched;

  localparam int N    = 4;
  localparam int P    = 16;
  localparam int ITER = 4;
`ifdef PRI_ISLIP_EARLY_EXIT_EN
  localparam int LAT_ONE  = 5;
  localparam int LAT_ZERO = 3;
`else
  localparam int LAT_ONE  = 9;
  localparam int LAT_ZERO = 9;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   pulses;

  pri_islip_sched_if #(.N(N), .P(P)) bus ();

  pri_islip_sched #(.N(N), .P(P), .ITER(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, measure cycles to decision_ready, check pulse shape.
  task automatic run_round(output int latency);
    bit seen;
    seen = 1'b0;
    latency = -1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.decision_ready) begin
        seen = 1'b1;
        latency = c;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL round_timeout: observed no decision_ready expected pulse within 60 cycles");
    end else begin
      chk("busy_at_pulse", bus.busy, 0);
      @(negedge clk);
      chk("pulse_width", bus.decision_ready, 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.pri_req_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_decision", bus.decision, 0);
    chk("reset_ready", bus.decision_ready, 0);
    chk("reset_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b1;

    // Abort a round with reset.
    bus.pri_req_in[2][1] = 4'd5;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_decision", bus.decision, 0);
    chk("abort_ready", bus.decision_ready, 0);
    chk("abort_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.decision_ready) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_decision_held", bus.decision, 0);

    // All-zero request matrix.
    bus.pri_req_in = '0;
    run_round(lat);
    chk("zero_latency", lat, LAT_ZERO);
    chk("zero_decision", bus.decision, 0);

    // Single request.
    bus.pri_req_in[2][1] = 4'd5;
    run_round(lat);
    chk("single_latency", lat, LAT_ONE);
    chk("single_decision", bus.decision, 64'h0200);

    // Priority beats round-robin.
    bus.pri_req_in = '0;
    bus.pri_req_in[0][2] = 4'd3;
    bus.pri_req_in[3][2] = 4'd9;
    run_round(lat);
    chk("priority_decision", bus.decision, 64'h4000);

    // Equal-priority contention for output 0 rotates through inputs.
    bus.pri_req_in = '0;
    for (int i = 0; i < N; i++) bus.pri_req_in[i][0] = 4'd7;
    for (int k = 0; k < N; k++) begin
      run_round(lat);
      chk($sformatf("rr_round%0d", k), bus.decision, 64'h1 << (4 * k));
    end

    // Full matrix from fresh pointers.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.pri_req_in[i][j] = 4'd1;
    run_round(lat);
    chk("full_latency", lat, 9);
    chk("full_round1", bus.decision, 64'h8421);
    run_round(lat);
    chk("full_round2", bus.decision, 64'h8412);

    // start while busy is ignored; request changes mid-round are ignored.
    bus.pri_req_in = '0;
    bus.pri_req_in[1][3] = 4'd4;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.pri_req_in[i][j] = 4'd15;
    pulses = 0;
    bus.start = 1'b1;
    @(negedge clk);
    if (bus.decision_ready) pulses++;
    @(negedge clk);
    if (bus.decision_ready) pulses++;
    bus.start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus.decision_ready) pulses++;
    end
    chk("busy_start_pulses", pulses, 1);
    chk("busy_start_decision", bus.decision, 64'h0080);
    chk("idle_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pri_islip_sched.md
Name: pri_islip_sched

Overview:
- Parametrised N x N priority iSLIP crossbar scheduler; successor to the fixed 4x4, fixed 4-iteration priority scheduler.
- Latches a matrix of per-VOQ priority requests on start.
- Runs ITER request-grant-accept iterations, using round-robin tie-breaking inside each priority level.
- Presents a conflict-free input/output match to the crossbar control path.

Parameters:
- N, 4, number of input ports and output ports (N >= 2).
- P, 16, number of priority levels; PW = $clog2(P) bits per request; value 0 = no request, higher value = higher priority.
- ITER, 4, maximum iterations per scheduling round (1 <= ITER <= N).

Ports:
- clk  in  1  scheduler clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  begin a scheduling round; sampled only in IDLE.
- pri_req_in  in  [N][N]x PW  pri_req_in[i][j] = priority of input i's request for output j.
- decision  out  [N][N]  decision[i][j] = 1 when input i is matched to output j.
- decision_ready  out  1  single-cycle pulse; decision has just been updated.
- busy  out  1  high from the cycle after start is accepted until DONE completes.

Behaviour:
- Reset (async, active-low):
  - state = IDLE; decision = 0; decision_ready = 0; busy = 0.
  - All grant pointers gnt_ptr[j] and accept pointers acc_ptr[i] = 0.
  - The internal request latch and the working match are cleared.
  - Reset asserted mid-round aborts the round; decision stays 0.
- FSM: IDLE -> GRANT -> ACCEPT -> (GRANT | DONE) -> IDLE.
  - IDLE: when start = 1, latch pri_req_in, clear the working match, set it = 0, go to GRANT.
  - GRANT (1 cycle): for each output j not yet matched:
    - Consider requests from unmatched inputs only.
    - Select the highest priority among them.
    - Break ties by round-robin, starting at gnt_ptr[j].
    - Register one-hot grant and winning priority per output.
  - ACCEPT (1 cycle): for each unmatched input i:
    - Consider the grants it received.
    - Select the highest priority among them.
    - Break ties by round-robin from acc_ptr[i].
    - Add the accepted pairs to the working match.
    - Increment it; go to DONE when it == ITER, otherwise go to GRANT.
  - DONE (1 cycle): decision <= working match; decision_ready = 1; go to IDLE.
- Pointer update (iSLIP rule): only for pairs accepted in iteration 0.
  - gnt_ptr[j] <= (i+1) mod N.
  - acc_ptr[i] <= (j+1) mod N.
  - Pointers do not move for matches made in later iterations, or for grants that are not accepted.
- Latency: decision_ready asserts exactly 2*ITER+1 cycles after the clk edge that samples start (feature disabled).
- decision holds its value between DONE pulses.
- start outside IDLE (including in DONE) is ignored; pri_req_in changes during a round are ignored.
- An all-zero request matrix produces decision = 0, and decision_ready still pulses.
- Invariant: each row and each column of decision has at most one set bit.

Optional Feature:
- Macro: PRI_ISLIP_EARLY_EXIT_EN.
- Defined: ACCEPT goes to DONE after any iteration that adds no new pair, and also when it == ITER. Latency is 2*k+1 cycles, where k is the number of iterations executed.
- Undefined: ITER iterations always run; latency is fixed at 2*ITER+1.

Decomposition:
- Package pri_sched_pkg holds:
  - state_t enum {IDLE, GRANT, ACCEPT, DONE};
  - a localparam function for the PW width;
  - a helper function for the pointer increment modulo N.
- Sub-module pri_rr_arbiter, parametrised by N and P. Instantiated N times as grant arbiters and N times as accept arbiters.
  - Inputs: N x PW priority requests, pointer.
  - Outputs: one-hot grant, winning priority, any_gnt.
  - Purely combinational, with priority-then-round-robin selection.
  - Pointer registers live in the top level.

Test Plan:
- Reset: hold reset = 0 mid-round -> decision = 0, decision_ready = 0, busy = 0; after release with zero requests and start -> decision = 0 with a pulse at cycle 9 (N = 4, ITER = 4).
- Single request: pri_req_in[2][1] = 5, start -> decision[2][1] = 1 only, decision_ready pulses 9 cycles after start.
- Priority: pri_req_in[0][2] = 3 and pri_req_in[3][2] = 9 -> decision[3][2] = 1; decision[0][*] = 0.
- Round-robin tie: every input requests output 0 at priority 7, repeated for 4 rounds -> input 0, 1, 2, 3 win in turn.
- Full matrix: all 16 requests at priority 1 from reset -> decision = identity (diagonal) after 4 iterations; a second round gives a different perfect match.
- start asserted while busy -> ignored, no extra pulse. With PRI_ISLIP_EARLY_EXIT_EN, the single-request case pulses at cycle 5.
